// File: rtl/memory_stage.sv
// Pipeline MEM stage: forwards ALU results in one cycle and holds loads/stores
// in WAIT_MEM until the data memory returns a single-cycle ack.
module memory_stage #(
    parameter int DATA_W = 24,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              writeback_enable_in,
    input  logic              mem_read_enable_in,
    input  logic              mem_write_enable_in,
    input  logic [DEST_W-1:0] instruction_dest_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              writeback_enable,
    output logic              mem_read_enable,
    output logic [DEST_W-1:0] instruction_dest,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  mem_wait_cycles
);

    // state    | meaning
    // S_IDLE   | ready for a new bundle; non-memory ops complete here
    // S_WAIT   | load/store outstanding, mem_req held until mem_ack
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cap_wb_en;
    logic              r_cap_is_load;
    logic [DEST_W-1:0] r_cap_dest;

    logic              r_wb_valid;
    logic              r_wb_en;
    logic              r_rd_en;
    logic [DEST_W-1:0] r_dest;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_alu;
    logic [CNT_W-1:0]  r_cnt;

    logic w_idle;
    logic w_accept;
    logic w_is_mem;
    logic w_cnt_sat;

    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = in_valid && w_idle;
    assign w_is_mem  = mem_read_enable_in || mem_write_enable_in;
    assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cap_wb_en   <= 1'b0;
            r_cap_is_load <= 1'b0;
            r_cap_dest    <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_dest        <= '0;
            r_rdata       <= '0;
            r_alu         <= '0;
            r_cnt         <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            r_state       <= S_WAIT;
                            // read+write together is treated as a plain load
                            r_mem_we      <= mem_write_enable_in && !mem_read_enable_in;
                            r_mem_addr    <= alu_result_in;
                            r_mem_wdata   <= store_data_in;
                            r_cap_wb_en   <= writeback_enable_in;
                            r_cap_is_load <= mem_read_enable_in;
                            r_cap_dest    <= instruction_dest_in;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_en    <= writeback_enable_in;
                            r_rd_en    <= 1'b0;
                            r_dest     <= instruction_dest_in;
                            r_rdata    <= '0;
                            r_alu      <= alu_result_in;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (mem_ack) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_en    <= r_cap_wb_en;
                        r_rd_en    <= r_cap_is_load;
                        r_dest     <= r_cap_dest;
                        r_rdata    <= r_cap_is_load ? mem_rdata : '0;
                        r_alu      <= r_mem_addr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready         = w_idle;
    assign mem_req          = !w_idle;
    assign mem_we           = r_mem_we && !w_idle;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign wb_valid         = r_wb_valid;
    assign writeback_enable = r_wb_en && r_wb_valid;
    assign mem_read_enable  = r_rd_en;
    assign instruction_dest = r_dest;
    assign mem_read_data    = r_rdata;
    assign alu_result       = r_alu;
    assign mem_wait_cycles  = r_cnt;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed bundles push expected MEM/WB
// results; a negedge monitor pops and compares whenever wb_valid is high.
module tb_memory_stage;
    localparam int DW = 24;
    localparam int WW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wb_en_in = 1'b0;
    logic          rd_in = 1'b0;
    logic          wr_in = 1'b0;
    logic [WW-1:0] dest_in = '0;
    logic [DW-1:0] alu_in = '0;
    logic [DW-1:0] sd_in = '0;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          writeback_enable;
    logic          mem_read_enable;
    logic [WW-1:0] instruction_dest;
    logic [DW-1:0] mem_read_data;
    logic [DW-1:0] alu_result;
    logic          wb_valid;
    logic [CW-1:0] mem_wait_cycles;

    always #5 clk = ~clk;

    memory_stage #(.DATA_W(DW), .DEST_W(WW), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .writeback_enable_in (wb_en_in),
        .mem_read_enable_in  (rd_in),
        .mem_write_enable_in (wr_in),
        .instruction_dest_in (dest_in),
        .alu_result_in       (alu_in),
        .store_data_in       (sd_in),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .writeback_enable    (writeback_enable),
        .mem_read_enable     (mem_read_enable),
        .instruction_dest    (instruction_dest),
        .mem_read_data       (mem_read_data),
        .alu_result          (alu_result),
        .wb_valid            (wb_valid),
        .mem_wait_cycles     (mem_wait_cycles)
    );

    typedef struct {
        logic [WW-1:0] dest;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
        logic          rd;
        logic          wb;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [WW-1:0] dest, input logic [DW-1:0] alu,
                        input logic [DW-1:0] rdata, input logic rd, input logic wb,
                        input logic [CW-1:0] cnt);
        exp_t e;
        e.dest = dest; e.alu = alu; e.rdata = rdata; e.rd = rd; e.wb = wb; e.cnt = cnt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", wb_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("wb_dest", instruction_dest, e.dest);
                chk("wb_alu", alu_result, e.alu);
                chk("wb_rdata", mem_read_data, e.rdata);
                chk("wb_rd_en", mem_read_enable, e.rd);
                chk("wb_wb_en", writeback_enable, e.wb);
                chk("wb_cnt", mem_wait_cycles, e.cnt);
            end
        end else if (rst_n) begin
            chk("wb_en_gated", writeback_enable, 0);
        end
    end

    // Called 1ns after a rising edge while the stage is idle; accepted at the next edge.
    task automatic issue(input logic wb, input logic rd, input logic wr, input logic [WW-1:0] dest,
                         input logic [DW-1:0] alu, input logic [DW-1:0] sd);
        chk("in_ready_pre", in_ready, 1);
        in_valid = 1'b1; wb_en_in = wb; rd_in = rd; wr_in = wr;
        dest_in = dest; alu_in = alu; sd_in = sd;
        @(posedge clk); #1;
        in_valid = 1'b0; wb_en_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0;
        dest_in = '0; alu_in = '0; sd_in = '0;
    endtask

    // Keeps the request outstanding for n cycles, acking in the last one.
    task automatic wait_ack(input int n, input logic [DW-1:0] rdata, input logic we,
                            input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(negedge clk);
            chk("mem_req_wait", mem_req, 1);
            chk("in_ready_wait", in_ready, 0);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, addr);
            if (we) chk("mem_wdata", mem_wdata, wdata);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_en"}, writeback_enable, 0);
        chk({tag, "_rd_en"}, mem_read_enable, 0);
        chk({tag, "_dest"}, instruction_dest, 0);
        chk({tag, "_rdata"}, mem_read_data, 0);
        chk({tag, "_alu"}, alu_result, 0);
        chk({tag, "_cnt"}, mem_wait_cycles, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("in_ready_release", in_ready, 1);

        // ALU op: one-cycle result, no memory request
        push(4'd3, 24'h00ABCD, 24'h0, 1'b0, 1'b1, 16'd0);
        issue(1'b1, 1'b0, 1'b0, 4'd3, 24'h00ABCD, 24'h0);
        @(negedge clk);
        chk("alu_no_req", mem_req, 0);
        @(posedge clk); #1;

        // load acked after three cycles, then a store accepted right after the ack cycle
        push(4'd5, 24'h000010, 24'h123456, 1'b1, 1'b1, 16'd3);
        issue(1'b1, 1'b1, 1'b0, 4'd5, 24'h000010, 24'h0);
        wait_ack(3, 24'h123456, 1'b0, 24'h000010, 24'h0);

        push(4'd7, 24'h000020, 24'h0, 1'b0, 1'b0, 16'd4);
        issue(1'b0, 1'b0, 1'b1, 4'd7, 24'h000020, 24'h00FFEE);
        wait_ack(1, 24'h999999, 1'b1, 24'h000020, 24'h00FFEE);

        // read and write together behave as a load
        push(4'd9, 24'h000030, 24'hA5A5A5, 1'b1, 1'b1, 16'd6);
        issue(1'b1, 1'b1, 1'b1, 4'd9, 24'h000030, 24'h55AA55);
        wait_ack(2, 24'hA5A5A5, 1'b0, 24'h000030, 24'h0);

        // back-to-back ALU ops, second without writeback
        push(4'd1, 24'h111111, 24'h0, 1'b0, 1'b1, 16'd6);
        issue(1'b1, 1'b0, 1'b0, 4'd1, 24'h111111, 24'h0);
        push(4'd2, 24'h222222, 24'h0, 1'b0, 1'b0, 16'd6);
        issue(1'b0, 1'b0, 1'b0, 4'd2, 24'h222222, 24'h0);
        @(posedge clk); #1;

        // stray ack while idle changes nothing
        mem_ack = 1'b1; mem_rdata = 24'hDEAD00;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("stray_in_ready", in_ready, 1);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_wb_valid", wb_valid, 0);
        chk("stray_dest", instruction_dest, 2);
        chk("stray_alu", alu_result, 24'h222222);
        chk("stray_rdata", mem_read_data, 0);
        chk("stray_rd_en", mem_read_enable, 0);
        chk("stray_cnt", mem_wait_cycles, 6);
        @(posedge clk); #1;

        // reset while a load is outstanding; the late ack must be ignored
        issue(1'b1, 1'b1, 1'b0, 4'hA, 24'h000050, 24'h0);
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("in_ready_release2", in_ready, 1);
        mem_ack = 1'b1; mem_rdata = 24'h777777;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk_zero("late_ack");
        @(posedge clk); #1;

        // wait counter saturates at all-ones
        push(4'd4, 24'h000040, 24'h0BEEF0, 1'b1, 1'b1, 16'hFFFF);
        issue(1'b1, 1'b1, 1'b0, 4'd4, 24'h000040, 24'h0);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("cnt_at_max", mem_wait_cycles, 16'hFFFF);
        chk("sat_mem_req", mem_req, 1);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 24'h0BEEF0;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("cnt_sat_hold", mem_wait_cycles, 16'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning data/address width.
REQ-002 SHALL have parameter DEST_W, default 4, meaning destination register index width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning wait-cycle counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  EX/MEM bundle valid.
REQ-007 SHALL have port in_ready  output  1  stage accepts bundle this cycle.
REQ-008 SHALL have port writeback_enable_in  input  1  instruction writes the register file.
REQ-009 SHALL have port mem_read_enable_in  input  1  load instruction.
REQ-010 SHALL have port mem_write_enable_in  input  1  store instruction.
REQ-011 SHALL have port instruction_dest_in  input  DEST_W  destination register.
REQ-012 SHALL have port alu_result_in  input  DATA_W  ALU result; memory address for load/store.
REQ-013 SHALL have port store_data_in  input  DATA_W  store data.
REQ-014 SHALL have port mem_req  output  1  data-memory request.
REQ-015 SHALL have port mem_we  output  1  request is a write.
REQ-016 SHALL have port mem_addr  output  DATA_W  request address.
REQ-017 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-018 SHALL have port mem_ack  input  1  one-cycle completion pulse.
REQ-019 SHALL have port mem_rdata  input  DATA_W  read data, valid when mem_ack=1.
REQ-020 SHALL have port writeback_enable  output  1  to writeback stage; gated by wb_valid.
REQ-021 SHALL have port mem_read_enable  output  1  to writeback stage; selects mem_read_data.
REQ-022 SHALL have port instruction_dest  output  DEST_W  to writeback stage.
REQ-023 SHALL have port mem_read_data  output  DATA_W  to writeback stage.
REQ-024 SHALL have port alu_result  output  DATA_W  to writeback stage.
REQ-025 SHALL have port wb_valid  output  1  MEM/WB register holds a real instruction.
REQ-026 SHALL have port mem_wait_cycles  output  CNT_W  count of cycles spent in WAIT_MEM.

Function
REQ-027 SHALL implement FSM states IDLE and WAIT_MEM; in_ready=1 only in IDLE.
REQ-028 SHALL accept a bundle when in_valid=1 and in_ready=1.
REQ-029 SHALL, on accepting a non-memory bundle (read=0, write=0), load MEM/WB outputs at that edge: wb_valid=1, mem_read_data=0, remain IDLE (1-cycle latency).
REQ-030 SHALL, on accepting a load or store, capture address/data/control, enter WAIT_MEM, set wb_valid=0 (bubble).
REQ-031 SHALL drive mem_req=1 throughout WAIT_MEM and 0 in IDLE; mem_we, mem_addr, mem_wdata held stable while mem_req=1.
REQ-032 SHALL treat read=1 and write=1 together as a load: mem_we=0, no write issued.
REQ-033 SHALL, in WAIT_MEM with mem_ack=1, load MEM/WB outputs (mem_read_data=mem_rdata for load, 0 for store), set wb_valid=1, return to IDLE.
REQ-034 SHALL hold wb_valid=0 every cycle in WAIT_MEM without ack and every IDLE cycle with no accept.
REQ-035 SHALL drive writeback_enable = captured writeback_enable AND wb_valid; store completion drives captured value (normally 0).
REQ-036 SHALL ignore mem_ack while in IDLE (no state or output change).
REQ-037 SHALL increment mem_wait_cycles once per cycle in WAIT_MEM, saturating at all-ones.
REQ-038 SHALL not accept a new bundle in the cycle mem_ack returns; next accept earliest one cycle later.

Reset
REQ-039 SHALL, while rst_n=0 (asynchronous assertion), force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, writeback_enable=0, mem_read_enable=0, instruction_dest=0, mem_read_data=0, alu_result=0, mem_wait_cycles=0.
REQ-040 SHALL, on reset during WAIT_MEM, abandon the outstanding access; a later mem_ack is ignored per REQ-036.
REQ-041 SHALL leave in_ready=1 during and immediately after reset release.

Verification
REQ-042 ALU op: dest=3, alu=0x00ABCD, wb_en=1 -> next edge wb_valid=1, instruction_dest=3, alu_result=0x00ABCD, writeback_enable=1, mem_req never asserted.
REQ-043 Load: addr=0x000010, ack 3 cycles later with rdata=0x123456 -> mem_req high 3 cycles, in_ready=0, then wb_valid=1, mem_read_enable=1, mem_read_data=0x123456, mem_wait_cycles=3.
REQ-044 Store: addr=0x000020, data=0x00FFEE, ack after 1 cycle -> mem_we=1, mem_wdata=0x00FFEE, then wb_valid=1, writeback_enable=0.
REQ-045 Stray mem_ack in IDLE -> no change to any output.
REQ-046 rst_n=0 mid WAIT_MEM, release, then ack -> all outputs zero, state IDLE, ack ignored.
REQ-047 Counter at 0xFFFF plus 2 more WAIT_MEM cycles -> mem_wait_cycles stays 0xFFFF.
